// File: rtl/e_mdu_pkg.sv
// Shared opcode encodings, result type and decode helpers for the E-stage multiply/divide unit.
package e_mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_pair_t;

  function automatic logic is_md_arith(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Bundle between the E/D pipeline stages and the multiply/divide unit.
interface e_mdu_if;
  logic        E_valid;
  logic [3:0]  E_mdop;
  logic [31:0] E_rs_m;
  logic [31:0] E_rt_m;
  logic        D_is_md;
  logic [31:0] md_rd;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output E_valid, E_mdop, E_rs_m, E_rt_m, D_is_md,
    input  md_rd, md_busy, md_stall, hi, lo
  );

  modport slave (
    input  E_valid, E_mdop, E_rs_m, E_rt_m, D_is_md,
    output md_rd, md_busy, md_stall, hi, lo
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: produces the {hi,lo} pair for one MD arithmetic op.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output md_pair_t    res,
  output logic        div_by_zero
);

  logic        is_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign is_signed = (op == MD_MULT) || (op == MD_DIV);

  // Low 64 bits of a 64x64 product of extended operands is the exact 32x32 result.
  assign mul_a = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign mul_b = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod  = mul_a * mul_b;

  // Division by magnitude avoids the INT_MIN / -1 overflow corner; 0x80000000 negates to itself.
  assign a_neg  = is_signed & a[31];
  assign b_neg  = is_signed & b[31];
  assign a_mag  = a_neg ? (32'd0 - a) : a;
  assign b_mag  = b_neg ? (32'd0 - b) : b;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  assign div_by_zero = is_md_div(op) && (b == 32'd0);

  always_comb begin
    res = '0;
    if (is_md_div(op)) begin
      res.hi = rem;
      res.lo = quot;
    end else begin
      res.hi = prod[63:32];
      res.lo = prod[31:0];
    end
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with architectural HI/LO and D-stage stall.
//   state | meaning
//   IDLE  | cnt == 0, accepts MULT/DIV start and MTHI/MTLO
//   BUSY  | cnt  > 0, result pending, commits to hi/lo when cnt reaches 1
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   clk,
  input  logic   rst_n,
  e_mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [CW-1:0] cnt;
  logic [0:0]    state;
  logic          busy;
  logic          start;
  logic          commit;
  logic          mthi;
  logic          mtlo;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  md_pair_t      pend;
  logic          pend_wr;
  md_pair_t      calc_res;
  logic          calc_dz;

  mdu_calc u_calc (
    .op          (bus.E_mdop),
    .a           (bus.E_rs_m),
    .b           (bus.E_rt_m),
    .res         (calc_res),
    .div_by_zero (calc_dz)
  );

  assign state  = (cnt != '0) ? ST_BUSY : ST_IDLE;
  assign busy   = (state == ST_BUSY);
  assign start  = bus.E_valid && is_md_arith(bus.E_mdop) && !busy;
  assign commit = busy && (cnt == CW'(1));
  assign mthi   = bus.E_valid && (bus.E_mdop == MD_MTHI) && !busy;
  assign mtlo   = bus.E_valid && (bus.E_mdop == MD_MTLO) && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
    end else if (start) begin
      cnt     <= is_md_div(bus.E_mdop) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      pend    <= calc_res;
      pend_wr <= !calc_dz;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Commit only happens while busy and MTHI/MTLO only while idle, so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (pend_wr) begin
        hi_q <= pend.hi;
        lo_q <= pend.lo;
      end
    end else begin
      if (mthi) hi_q <= bus.E_rs_m;
      if (mtlo) lo_q <= bus.E_rs_m;
    end
  end

  always_comb begin
    bus.md_rd = '0;
    if (bus.E_mdop == MD_MFHI)      bus.md_rd = hi_q;
    else if (bus.E_mdop == MD_MFLO) bus.md_rd = lo_q;
  end

  assign bus.md_busy  = busy;
  assign bus.md_stall = bus.D_is_md && (start || busy);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: arithmetic results, busy/stall timing, MT/MF and reset abort.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   viol;
  int   busy_n;
  int   stall_n;

  e_mdu_if mdu_bus ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mdu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MD op reaching E while busy means the stall logic let one through.
  always @(posedge clk)
    if (rst_n && mdu_bus.md_busy && mdu_bus.E_valid && (mdu_bus.E_mdop != MD_NONE))
      viol++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bubble();
    mdu_bus.E_valid = 1'b0;
    mdu_bus.E_mdop  = MD_NONE;
    mdu_bus.E_rs_m  = '0;
    mdu_bus.E_rt_m  = '0;
  endtask

  // Issue one MD arithmetic op, then count busy and stall cycles until the unit goes idle.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d_md, output int nb, output int ns);
    @(negedge clk);
    mdu_bus.E_valid = 1'b1;
    mdu_bus.E_mdop  = op;
    mdu_bus.E_rs_m  = a;
    mdu_bus.E_rt_m  = b;
    mdu_bus.D_is_md = d_md;
    #1;
    ns = mdu_bus.md_stall ? 1 : 0;
    nb = 0;
    @(negedge clk);
    bubble();
    #1;
    while (mdu_bus.md_busy && nb < 40) begin
      nb++;
      if (mdu_bus.md_stall) ns++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic single(input logic [3:0] op, input logic [31:0] a);
    @(negedge clk);
    mdu_bus.E_valid = 1'b1;
    mdu_bus.E_mdop  = op;
    mdu_bus.E_rs_m  = a;
    mdu_bus.E_rt_m  = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    viol     = 0;
    rst_n    = 1'b0;
    mdu_bus.D_is_md = 1'b0;
    bubble();
    repeat (2) @(negedge clk);
    #1;
    check("rst_hi", mdu_bus.hi, 32'h0);
    check("rst_lo", mdu_bus.lo, 32'h0);
    check("rst_busy", 32'(mdu_bus.md_busy), 32'd0);
    check("rst_stall", 32'(mdu_bus.md_stall), 32'd0);
    rst_n = 1'b1;

    run_md(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0, busy_n, stall_n);
    check("mult_busy", 32'(busy_n), 32'd5);
    check("mult_hi", mdu_bus.hi, 32'hFFFFFFFF);
    check("mult_lo", mdu_bus.lo, 32'hFFFFFFFA);

    run_md(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, busy_n, stall_n);
    check("multu_busy", 32'(busy_n), 32'd5);
    check("multu_hi", mdu_bus.hi, 32'hFFFFFFFE);
    check("multu_lo", mdu_bus.lo, 32'h00000001);

    run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, busy_n, stall_n);
    check("div_busy", 32'(busy_n), 32'd10);
    check("div_lo", mdu_bus.lo, 32'hFFFFFFFD);
    check("div_hi", mdu_bus.hi, 32'hFFFFFFFF);

    run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, busy_n, stall_n);
    check("divovf_lo", mdu_bus.lo, 32'h80000000);
    check("divovf_hi", mdu_bus.hi, 32'h00000000);

    run_md(MD_DIVU, 32'd7, 32'd0, 1'b0, busy_n, stall_n);
    check("div0_busy", 32'(busy_n), 32'd10);
    check("div0_lo", mdu_bus.lo, 32'h80000000);
    check("div0_hi", mdu_bus.hi, 32'h00000000);

    run_md(MD_DIVU, 32'hFFFFFFF0, 32'd16, 1'b0, busy_n, stall_n);
    check("divu_lo", mdu_bus.lo, 32'h0FFFFFFF);
    check("divu_hi", mdu_bus.hi, 32'h00000000);

    // DIV in E with MFLO waiting in D; MFLO enters E the cycle the stall drops.
    run_md(MD_DIV, 32'd100, 32'd7, 1'b1, busy_n, stall_n);
    check("stall_cycles", 32'(stall_n), 32'd11);
    mdu_bus.D_is_md = 1'b0;
    mdu_bus.E_valid = 1'b1;
    mdu_bus.E_mdop  = MD_MFLO;
    #1;
    check("mflo_quot", mdu_bus.md_rd, 32'd14);
    check("div_rem", mdu_bus.hi, 32'd2);

    single(MD_MTHI, 32'h12345678);
    single(MD_MFHI, 32'h0);
    #1;
    check("mthi_mfhi", mdu_bus.md_rd, 32'h12345678);
    single(MD_MTLO, 32'hCAFEF00D);
    single(MD_MFLO, 32'h0);
    #1;
    check("mtlo_mflo", mdu_bus.md_rd, 32'hCAFEF00D);
    check("mtlo_hi_kept", mdu_bus.hi, 32'h12345678);
    @(negedge clk);
    bubble();
    #1;
    check("rd_none", mdu_bus.md_rd, 32'h0);

    run_md(MD_MULT, 32'h00012345, 32'h00100000, 1'b0, busy_n, stall_n);
    check("nostall_cycles", 32'(stall_n), 32'd0);
    check("mult2_hi", mdu_bus.hi, 32'h00000012);
    check("mult2_lo", mdu_bus.lo, 32'h34500000);

    // Reset in the third busy cycle of a DIV aborts it without a later commit.
    @(negedge clk);
    mdu_bus.E_valid = 1'b1;
    mdu_bus.E_mdop  = MD_DIV;
    mdu_bus.E_rs_m  = 32'd50;
    mdu_bus.E_rt_m  = 32'd5;
    @(negedge clk);
    bubble();
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_busy", 32'(mdu_bus.md_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(mdu_bus.md_busy), 32'd0);
    check("abort_hi", mdu_bus.hi, 32'h0);
    check("abort_lo", mdu_bus.lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("no_commit_lo", mdu_bus.lo, 32'h0);
    check("no_commit_busy", 32'(mdu_bus.md_busy), 32'd0);

    check("md_in_e_while_busy", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
